// File: rtl/wb_commit_stage.sv
// wb_commit_stage: writeback/commit stage in front of the integer register file.
// Retiring instructions are accepted over a valid/ready handshake into a small
// in-order buffer, with the writeback value formatted at push time. One entry
// per cycle is then committed to the register file write port. The stage also
// counts retired instructions and raises a sticky finish when a halt commits.
// Optional feature: define WB_FWD_EN to expose the youngest pending register
// write (fwd_valid/fwd_rd/fwd_data) so decode can forward from the buffer.
module wb_commit_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [1:0]      mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_raw,
    input  logic [2:0]      mem_funct3,
    input  logic [2:0]      mem_addr_lo,
    input  logic            mem_halt,
    input  logic            wb_stall,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] reg_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     instret,
    output logic            finish
`ifdef WB_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    // Picks the lane (misaligned offsets aligned down to the access size)
    // and sign- or zero-extends it; funct3 111 yields zero.
    function automatic logic [XLEN-1:0] load_format(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      f3,
        input logic [2:0]      lo
    );
        logic [2:0]      lane;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] res;
        case (f3[1:0])
            2'b00:   lane = lo;
            2'b01:   lane = {lo[2:1], 1'b0};
            2'b10:   lane = {lo[2], 2'b00};
            default: lane = 3'b000;
        endcase
        b = raw[{lane, 3'b000} +: 8];
        h = raw[{lane, 3'b000} +: 16];
        w = raw[{lane, 3'b000} +: 32];
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b010:  res = {{(XLEN-32){w[31]}}, w};
            3'b011:  res = raw;
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            3'b110:  res = {{(XLEN-32){1'b0}}, w};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Writeback source select; encoding 11 falls back to the ALU result.
    function automatic logic [XLEN-1:0] wb_value(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] raw,
        input logic [2:0]      f3,
        input logic [2:0]      lo
    );
        logic [XLEN-1:0] v;
        case (sel)
            2'b01:   v = load_format(raw, f3, lo);
            2'b10:   v = pc + XLEN'(4);
            default: v = alu;
        endcase
        return v;
    endfunction

    // Buffer storage (data only, never reset)
    logic [XLEN-1:0] buf_pc_q   [DEPTH];
    logic [XLEN-1:0] buf_data_q [DEPTH];
    logic [4:0]      buf_rd_q   [DEPTH];
    logic            buf_we_q   [DEPTH];
    logic            buf_halt_q [DEPTH];

    // Control state
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          halt_seen_q, halt_seen_d;

    // Commit port registers
    logic            reg_write_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] reg_data_q;
    logic            commit_valid_q;
    logic [XLEN-1:0] commit_pc_q;
    logic [63:0]     instret_q;
    logic            finish_q;

    logic push, pop;

    assign mem_ready = !rst && (count_q < FULL) && !halt_seen_q;
    assign push      = mem_valid && mem_ready;
    assign pop       = (count_q != '0) && !wb_stall;

    // Next-state for pointers, occupancy and the halt latch
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (mem_halt) halt_seen_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + (PW+1)'(1);
        else if (!push && pop) count_d = count_q - (PW+1)'(1);
    end

    // Control registers; reset empties the buffer and clears the halt latch
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    // Buffer write with the writeback value already formatted
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= mem_pc;
            buf_data_q[wr_ptr_q] <= wb_value(mem_wb_sel, mem_pc, mem_alu_result,
                                             mem_load_raw, mem_funct3, mem_addr_lo);
            buf_rd_q[wr_ptr_q]   <= mem_rd;
            buf_we_q[wr_ptr_q]   <= mem_reg_write && (mem_rd != 5'd0);
            buf_halt_q[wr_ptr_q] <= mem_halt;
        end
    end

    // Commit port: register the popped head; rd/reg_data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q    <= 1'b0;
            rd_q           <= '0;
            reg_data_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            instret_q      <= '0;
            finish_q       <= 1'b0;
        end else begin
            commit_valid_q <= pop;
            reg_write_q    <= pop && buf_we_q[rd_ptr_q];
            if (pop) begin
                rd_q        <= buf_rd_q[rd_ptr_q];
                reg_data_q  <= buf_data_q[rd_ptr_q];
                commit_pc_q <= buf_pc_q[rd_ptr_q];
                instret_q   <= instret_q + 64'd1;
                if (buf_halt_q[rd_ptr_q]) finish_q <= 1'b1;
            end
        end
    end

    assign reg_write    = reg_write_q;
    assign rd           = rd_q;
    assign reg_data     = reg_data_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign instret      = instret_q;
    assign finish       = finish_q;

`ifdef WB_FWD_EN
    // Youngest pending write wins: scan oldest to youngest, later hits override
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < count_q) && buf_we_q[idx]) begin
                fwd_valid = 1'b1;
                fwd_rd    = buf_rd_q[idx];
                fwd_data  = buf_data_q[idx];
            end
        end
    end
`endif

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Writeback/commit stage sitting directly upstream of the 64-bit integer register file.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Formats load data, selects the writeback source, and drives the register file's write port one instruction per cycle.
- Tracks retired-instruction count and raises a sticky finish when a halt instruction commits.

Parameters:
- XLEN, 64, datapath and register width.
- DEPTH, 2, commit buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_valid  input  1  MEM stage presents an instruction
- mem_ready  output  1  stage can accept; transfer when mem_valid && mem_ready
- mem_pc  input  XLEN  instruction PC
- mem_rd  input  5  destination register index
- mem_reg_write  input  1  instruction writes rd
- mem_wb_sel  input  2  00 ALU, 01 load, 10 PC+4 link, 11 treated as ALU
- mem_alu_result  input  XLEN  ALU result
- mem_load_raw  input  XLEN  raw aligned doubleword read from data memory
- mem_funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- mem_addr_lo  input  3  byte offset of the load address within the doubleword
- mem_halt  input  1  instruction is the halt/ebreak marker
- wb_stall  input  1  hold commits this cycle
- reg_write  output  1  register file write enable
- rd  output  5  register file write index
- reg_data  output  XLEN  register file write data
- commit_valid  output  1  one-cycle pulse per retired instruction
- commit_pc  output  XLEN  PC of the retired instruction
- instret  output  64  retired-instruction counter
- finish  output  1  sticky; halt instruction has committed

Behaviour:
- Reset: buffer empty, halt_seen=0. Outputs: mem_ready=0 during reset, then 1 in the first cycle after rst deasserts. reg_write=0, rd=0, reg_data=0, commit_valid=0, commit_pc=0, instret=0, finish=0. Reset mid-operation discards all buffered entries; nothing is written to the register file.
- Accept:
  - mem_ready = (count < DEPTH) && !halt_seen.
  - On transfer, the entry is stored with its writeback value already formatted.
  - An accepted mem_halt sets halt_seen; no further accepts until reset.
- Value selection:
  - ALU and 11: mem_alu_result.
  - Link: mem_pc + 4, modulo 2^XLEN.
  - Load: lane = mem_addr_lo with its low bits cleared to the access size. Misaligned offsets are silently aligned down.
  - LB/LH/LW sign-extend the lane; LBU/LHU/LWU zero-extend; LD takes all 64 bits.
  - Load with funct3 111: value 0.
- Pop/commit:
  - When count>0 and !wb_stall, the head is popped.
  - On the next edge the outputs register: commit_valid=1, commit_pc, reg_write = entry.reg_write && entry.rd!=0, rd, reg_data.
  - When nothing is popped: commit_valid=0 and reg_write=0; rd and reg_data hold their values.
- Latency: transfer at edge k → reg_write/commit_valid high in the cycle after edge k+1, when not stalled and the buffer is otherwise empty.
- Throughput: one commit per cycle. Simultaneous push and pop leaves count unchanged; the pushed entry is always behind the popped one. Strict program order.
- x0 writes are suppressed (reg_write=0) but still commit (commit_valid=1, instret increments).
- instret increments on every commit and wraps at 2^64.
- finish: set on the edge that commits a halt entry; stays 1 until reset. Entries accepted before the halt all commit first.
- wb_stall while empty: no effect. wb_stall while full: mem_ready=0, contents held.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (5), fwd_data (XLEN).
  - They present the youngest buffered entry with reg_write=1 and rd!=0, combinationally from buffer state.
  - This lets decode forward values not yet written to the register file. fwd_valid=0 when no such entry exists.
- Not defined: ports absent; no forwarding logic.

Test Plan:
- ALU op rd=5, value 0x1234, accepted edge k → cycle after k+1: reg_write=1, rd=5, reg_data=0x1234, commit_valid=1, instret=1.
- LB, raw=0x00000000_80FF0000, addr_lo=2 → reg_data=0xFFFFFFFF_FFFFFFFF. Same with LBU → 0xFF. LH at addr_lo=3 (aligned down to 2) → 0xFFFFFFFF_FFFF80FF.
- JAL link, pc=0x80000000, rd=1 → reg_data=0x80000004. ALU op with rd=0 → reg_write=0, commit_valid=1.
- wb_stall held 5 cycles while 3 instructions are offered → mem_ready=0 after 2 accepts; on release, 3 commits in order on consecutive cycles.
- Halt then further valids → mem_ready=0 after the halt; finish=1 the cycle after the halt commits; instret equals the committed count. Assert rst → all outputs 0, mem_ready=1 the cycle after rst drops.
- With WB_FWD_EN, two buffered writes to rd=7 (0xA then 0xB) while stalled → fwd_valid=1, fwd_rd=7, fwd_data=0xB.
